registrador_pc: RTL and testbench

Program-counter register and instruction-phase sequencer for the multi-cycle core. Each instruction takes FASES clock cycles. This block holds the current PC (estado_pc) and feeds the PC adder. At the update phase it loads either the adder's sequential result (endereco_soma) or a pending branch target. It also emits the fetch and update strobes used by the rest of the datapath.

---
 rtl/registrador_pc_pkg.sv | 21 ++
 rtl/contador_fases.sv | 39 +++
 rtl/registrador_pc.sv | 114 +++++++++++
 tb/tb_registrador_pc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/registrador_pc_pkg.sv
// Shared core constants for the instruction-phase sequencing.
// The PC adder and the control unit import the same values, so all three
// blocks agree on the phase numbering and the legal address range.
package registrador_pc_pkg;

    localparam int FASES         = 10;   // cycles per instruction
    localparam int FASE_ATUALIZA = 9;    // phase in which the PC is written
    localparam int FASE_W        = 4;    // width of the phase counter
    localparam int MEM_PALAVRAS  = 256;  // instruction memory depth in words

    localparam logic [31:0]       PC_INICIAL     = 32'd0;
    localparam logic [FASE_W-1:0] FASE_ULTIMA    = FASE_W'(FASES - 1);
    localparam logic [FASE_W-1:0] FASE_ESCRITA   = FASE_W'(FASE_ATUALIZA);
    localparam logic [31:0]       LIMITE_MEMORIA = 32'(MEM_PALAVRAS);

    // True when a word address falls inside instruction memory.
    function automatic logic endereco_valido(input logic [31:0] endereco);
        return endereco < LIMITE_MEMORIA;
    endfunction

endpackage

// File: rtl/contador_fases.sv
// Phase counter for the multi-cycle core.
// Counts 0..FASES-1 and wraps. It advances only while habilita is high.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous, active-low; forces phase 0
//   habilita - advance one phase on this edge
//   fase     - current phase
//   inicio   - fase == 0 (fetch phase)
//   fim      - fase == FASE_ATUALIZA (PC-write phase)
module contador_fases
    import registrador_pc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              habilita,
    output logic [FASE_W-1:0] fase,
    output logic              inicio,
    output logic              fim
);

    logic [FASE_W-1:0] fase_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fase_q <= '0;
        end else if (habilita) begin
            if (fase_q == FASE_ULTIMA) begin
                fase_q <= '0;
            end else begin
                fase_q <= fase_q + FASE_W'(1);
            end
        end
    end

    assign fase   = fase_q;
    assign inicio = (fase_q == '0);
    assign fim    = (fase_q == FASE_ESCRITA);

endmodule

// File: rtl/registrador_pc.sv
// Program-counter register and instruction-phase sequencer.
// The block holds the current PC and steps through the phases of each
// instruction. In the update phase it loads one of three values: a live
// branch target, a previously latched branch target, or the adder's
// sequential address. An out-of-range next PC, or a halt request, stops
// the core until reset.
// Ports:
//   clock           - system clock, rising edge
//   reset           - asynchronous, active-low
//   endereco_soma   - estado_pc + 1 from the PC adder
//   desvio          - branch/jump taken pulse
//   endereco_desvio - branch/jump target, valid with desvio
//   stall           - freezes phase, PC and pending branch
//   halt            - halt request (sticky once accepted)
//   estado_pc       - current PC
//   fase            - current phase
//   busca           - fetch strobe
//   atualiza        - PC-write strobe
//   parado          - core halted (sticky)
//   erro_endereco   - out-of-range PC detected (sticky)
module registrador_pc
    import registrador_pc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] endereco_soma,
    input  logic        desvio,
    input  logic [31:0] endereco_desvio,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] estado_pc,
    output logic [3:0]  fase,
    output logic        busca,
    output logic        atualiza,
    output logic        parado,
    output logic        erro_endereco
);

    logic        ativo;
    logic        inicio;
    logic        fim;
    logic [31:0] pc_q;
    logic        pendente_q;
    logic [31:0] alvo_q;
    logic        parado_q;
    logic        erro_q;
    logic [31:0] proximo_pc;
    logic        proximo_valido;

    // Stall and halt both freeze all sequencing state.
    assign ativo = ~stall & ~parado_q;

    contador_fases u_contador_fases (
        .clock    (clock),
        .reset    (reset),
        .habilita (ativo),
        .fase     (fase),
        .inicio   (inicio),
        .fim      (fim)
    );

    assign busca    = inicio & ativo;
    assign atualiza = fim & ativo;

    // A branch raised during the update phase itself beats the latched one.
    always_comb begin
        proximo_pc = endereco_soma;
        if (desvio) begin
            proximo_pc = endereco_desvio;
        end else if (pendente_q) begin
            proximo_pc = alvo_q;
        end
    end

    assign proximo_valido = endereco_valido(proximo_pc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= PC_INICIAL;
            pendente_q <= 1'b0;
            parado_q   <= 1'b0;
            erro_q     <= 1'b0;
        end else if (ativo) begin
            if (fim) begin
                pendente_q <= 1'b0;
                if (proximo_valido) begin
                    pc_q <= proximo_pc;
                end else begin
                    // Keep the last good PC so software can see where it failed.
                    erro_q   <= 1'b1;
                    parado_q <= 1'b1;
                end
            end else if (desvio) begin
                pendente_q <= 1'b1;
            end
            // Halt on the update edge still lets that write complete.
            if (halt) begin
                parado_q <= 1'b1;
            end
        end
    end

    // The target is only meaningful while pendente_q is set, so it needs no reset.
    always_ff @(posedge clock) begin
        if (ativo && !fim && desvio) begin
            alvo_q <= endereco_desvio;
        end
    end

    assign estado_pc     = pc_q;
    assign parado        = parado_q;
    assign erro_endereco = erro_q;

endmodule

// File: tb/tb_registrador_pc.sv
module tb_registrador_pc;

    logic        clock;
    logic        reset;
    logic [31:0] endereco_soma;
    logic        desvio;
    logic [31:0] endereco_desvio;
    logic        stall;
    logic        halt;
    logic [31:0] estado_pc;
    logic [3:0]  fase;
    logic        busca;
    logic        atualiza;
    logic        parado;
    logic        erro_endereco;

    logic        forca_soma;
    logic [31:0] soma_forcada;

    int n_cmp;
    int n_err;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [3:0]  fase;
        logic        parado;
        logic        erro;
    } esperado_t;

    esperado_t sb[$];

    // Reference state derived from the behaviour description.
    logic [31:0] m_pc;
    logic [3:0]  m_fase;
    logic        m_pend;
    logic [31:0] m_alvo;
    logic        m_parado;
    logic        m_erro;

    registrador_pc dut (
        .clock           (clock),
        .reset           (reset),
        .endereco_soma   (endereco_soma),
        .desvio          (desvio),
        .endereco_desvio (endereco_desvio),
        .stall           (stall),
        .halt            (halt),
        .estado_pc       (estado_pc),
        .fase            (fase),
        .busca           (busca),
        .atualiza        (atualiza),
        .parado          (parado),
        .erro_endereco   (erro_endereco)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stand-in for the PC adder, with an override for the range test.
    always_comb begin
        endereco_soma = forca_soma ? soma_forcada : estado_pc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelo_reset();
        m_pc     = 32'd0;
        m_fase   = 4'd0;
        m_pend   = 1'b0;
        m_parado = 1'b0;
        m_erro   = 1'b0;
    endtask

    // One clock: check strobes, push the expected post-edge state,
    // clock the DUT, then pop and compare.
    task automatic ciclo(input string tag);
        esperado_t e;
        logic        at;
        logic [31:0] prox;
        #1;
        at = !stall && !m_parado;
        chk({tag, "_busca"},    {31'd0, busca},    {31'd0, (m_fase == 4'd0) && at});
        chk({tag, "_atualiza"}, {31'd0, atualiza}, {31'd0, (m_fase == 4'd9) && at});
        if (at) begin
            if (m_fase == 4'd9) begin
                prox = desvio ? endereco_desvio : (m_pend ? m_alvo : endereco_soma);
                if (prox >= 32'd256) begin
                    m_erro   = 1'b1;
                    m_parado = 1'b1;
                end else begin
                    m_pc = prox;
                end
                m_pend = 1'b0;
            end else if (desvio) begin
                m_pend = 1'b1;
                m_alvo = endereco_desvio;
            end
            if (halt) m_parado = 1'b1;
            m_fase = (m_fase == 4'd9) ? 4'd0 : m_fase + 4'd1;
        end
        e.tag = tag; e.pc = m_pc; e.fase = m_fase; e.parado = m_parado; e.erro = m_erro;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_pc"},     estado_pc,                  e.pc);
        chk({e.tag, "_fase"},   {28'd0, fase},              {28'd0, e.fase});
        chk({e.tag, "_parado"}, {31'd0, parado},            {31'd0, e.parado});
        chk({e.tag, "_erro"},   {31'd0, erro_endereco},     {31'd0, e.erro});
    endtask

    task automatic ciclos(input string tag, input int n);
        for (int i = 0; i < n; i++) ciclo(tag);
    endtask

    // Assert reset mid-cycle, check it acts without a clock, hold across an
    // edge, then release it away from the rising edge.
    task automatic aplica_reset(input string tag);
        reset = 1'b0;
        #1;
        modelo_reset();
        chk({tag, "_pc_async"},   estado_pc,               32'd0);
        chk({tag, "_fase_async"}, {28'd0, fase},           32'd0);
        @(posedge clock);
        #1;
        chk({tag, "_pc_hold"},    estado_pc,               32'd0);
        chk({tag, "_fase_hold"},  {28'd0, fase},           32'd0);
        chk({tag, "_parado"},     {31'd0, parado},         32'd0);
        chk({tag, "_erro"},       {31'd0, erro_endereco},  32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        desvio = 1'b0;
        endereco_desvio = 32'd0;
        stall = 1'b0;
        halt = 1'b0;
        forca_soma = 1'b0;
        soma_forcada = 32'd0;
        modelo_reset();
        @(posedge clock);
        #2;
        aplica_reset("rst0");

        // Sequential run.
        ciclos("seq", 30);
        chk("seq_pc_final", estado_pc, 32'd3);
        chk("seq_fase_final", {28'd0, fase}, 32'd0);

        // Single branch at phase 3.
        ciclos("br1_pre", 3);
        desvio = 1'b1; endereco_desvio = 32'h40;
        ciclo("br1_pulse");
        desvio = 1'b0; endereco_desvio = 32'hdead_beef;
        ciclos("br1_wait", 6);
        chk("br1_pc", estado_pc, 32'h40);
        ciclos("br1_next", 10);
        chk("br1_pc_inc", estado_pc, 32'h41);

        // Two branches in one instruction: last one wins.
        ciclos("br2_pre", 2);
        desvio = 1'b1; endereco_desvio = 32'h10;
        ciclo("br2_a");
        desvio = 1'b0;
        ciclos("br2_mid", 2);
        desvio = 1'b1; endereco_desvio = 32'h20;
        ciclo("br2_b");
        desvio = 1'b0;
        ciclos("br2_wait", 4);
        chk("br2_pc", estado_pc, 32'h20);

        // Branch raised in the update phase itself.
        ciclos("br3_pre", 9);
        desvio = 1'b1; endereco_desvio = 32'h30;
        ciclo("br3_live");
        desvio = 1'b0;
        chk("br3_pc", estado_pc, 32'h30);

        // Stall across the update phase; a branch during it is dropped.
        ciclos("stl_pre", 9);
        stall = 1'b1;
        desvio = 1'b1; endereco_desvio = 32'h77;
        ciclo("stl");
        desvio = 1'b0;
        ciclos("stl", 3);
        chk("stl_fase", {28'd0, fase}, 32'd9);
        chk("stl_pc", estado_pc, 32'h30);
        stall = 1'b0;
        ciclo("stl_upd");
        chk("stl_pc_after", estado_pc, 32'h31);

        // Out-of-range sequential address.
        ciclos("rng_pre", 9);
        forca_soma = 1'b1; soma_forcada = 32'd256;
        ciclo("rng");
        chk("rng_pc", estado_pc, 32'h31);
        chk("rng_erro", {31'd0, erro_endereco}, 32'd1);
        chk("rng_parado", {31'd0, parado}, 32'd1);
        ciclos("rng_frozen", 12);
        forca_soma = 1'b0;
        aplica_reset("rst1");

        // Halt mid-instruction.
        ciclos("hlt_pre", 4);
        halt = 1'b1;
        ciclo("hlt");
        halt = 1'b0;
        chk("hlt_parado", {31'd0, parado}, 32'd1);
        chk("hlt_fase", {28'd0, fase}, 32'd5);
        ciclos("hlt_frozen", 12);
        chk("hlt_fase_frozen", {28'd0, fase}, 32'd5);
        chk("hlt_pc_frozen", estado_pc, 32'd0);
        aplica_reset("rst2");

        // Reset with a branch pending discards it.
        ciclos("rpb_pre", 3);
        desvio = 1'b1; endereco_desvio = 32'h50;
        ciclo("rpb_pulse");
        desvio = 1'b0;
        ciclos("rpb_mid", 2);
        aplica_reset("rst3");
        ciclos("rpb_after", 10);
        chk("rpb_pc", estado_pc, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
